// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data memory.
// Each transaction takes IDLE (grant) -> ACCESS (memory cycle) -> RESP (ack pulse).
// Optional build macro DMEM_ARB_STATS_EN adds saturating per-port ack counters
// and a conflict counter (stat_cnt0, stat_cnt1, stat_conflict).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1,
  output logic [15:0]       stat_conflict
`endif
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q;
  logic   gnt_q;   // granted port of the transaction in flight
  logic   last_q;  // last granted port, drives round-robin priority
  logic   we_q;
  logic   oor_q;

  logic              pick;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Arbitration choice and the chosen port's request fields.
  always_comb begin
    // Port 1 wins when alone, or when both request and port 0 went last.
    pick      = req1 & ~(req0 & last_q);
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_oor   = (sel_addr >> ADDR_W) != 32'd0;
  end

  // Sequencer FSM; all outputs are registered so reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
`ifdef DMEM_ARB_STATS_EN
      stat_cnt0     <= '0;
      stat_cnt1     <= '0;
      stat_conflict <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            gnt_q     <= pick;
            last_q    <= pick;
            we_q      <= sel_we;
            oor_q     <= sel_oor;
            mem_addr  <= sel_addr[ADDR_W-1:0];
            mem_wdata <= sel_wdata;
            // Write strobe covers exactly the ACCESS cycle.
            mem_we    <= sel_we & ~sel_oor;
            state_q   <= StAccess;
`ifdef DMEM_ARB_STATS_EN
            if (req0 & req1) stat_conflict <= sat_inc(stat_conflict);
`endif
          end
        end
        StAccess: begin
          mem_we <= 1'b0;
          if (!we_q) begin
            if (gnt_q) rdata1 <= oor_q ? '0 : mem_rd;
            else       rdata0 <= oor_q ? '0 : mem_rd;
          end
          ack0    <= ~gnt_q;
          ack1    <= gnt_q;
          err0    <= ~gnt_q & oor_q;
          err1    <= gnt_q & oor_q;
          state_q <= StResp;
`ifdef DMEM_ARB_STATS_EN
          if (gnt_q) stat_cnt1 <= sat_inc(stat_cnt1);
          else       stat_cnt0 <= sat_inc(stat_cnt0);
`endif
        end
        StResp: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks, a monitor pops and checks.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0]   addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rd;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_cnt0, stat_cnt1, stat_conflict;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with a backdoor preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input logic p, input logic w, input logic e, input logic [31:0] rd,
                      input int c);
    exp_t x;
    x.port = p; x.we = w; x.err = e; x.rdata = rd; x.cyc = c;
    sbq.push_back(x);
  endtask

  // Monitor: on every ack pop the oldest expectation; also tallies write strobes.
  logic [31:0] model0 = '0, model1 = '0;
  int          we_cycles = 0;
  logic [31:0] we_addr = '0, we_data = '0;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      model0 = '0;
      model1 = '0;
    end else if (ack0 | ack1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none (cycle %0d)",
                 ack0, ack1, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ack_port", {31'b0, ack1}, {31'b0, e.port});
        chk("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
        chk("err", {31'b0, ack1 ? err1 : err0}, {31'b0, e.err});
        chk("err_other", {31'b0, ack1 ? err0 : err1}, 32'd0);
        chk("ack_latency", cyc, e.cyc);
        if (!e.we) begin
          if (e.port) model1 = e.rdata;
          else        model0 = e.rdata;
        end
        chk("rdata0", rdata0, model0);
        chk("rdata1", rdata1, model1);
      end
    end
    if (mem_we) begin
      we_cycles++;
      we_addr = {{(32-AW){1'b0}}, mem_addr};
      we_data = mem_wdata;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  // Single transaction from IDLE: drive, await ack (bounded), drop req in RESP.
  task automatic issue(input logic p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic er, input logic [31:0] rd);
    bit got;
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    push(p, w, er, rd, cyc + 2);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (p ? ack1 : ack0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack on port %0d expected ack within 20 cycles", p);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int w0;
  int c;

  initial begin
    @(posedge clk); #1;
    poke(16'd5,  32'hDEADBEEF);
    poke(16'd0,  32'hCAFE0000);
    poke(16'd7,  32'h00000000);
    poke(16'd10, 32'hA0A0A0A0);
    poke(16'd11, 32'hB1B1B1B1);
    poke(16'd20, 32'h11111111);

    // Reset state
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_ack1", {31'b0, ack1}, 32'd0);
    chk("rst_err", {30'b0, err1, err0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 read
    w0 = we_cycles;
    issue(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    chk("p0_read_no_we", we_cycles - w0, 32'd0);

    // Port 1 write then read-after-write
    w0 = we_cycles;
    issue(1'b1, 1'b1, 32'd7, 32'h12345678, 1'b0, 32'd0);
    chk("p1_write_we_cycles", we_cycles - w0, 32'd1);
    chk("p1_write_addr", we_addr, 32'd7);
    chk("p1_write_data", we_data, 32'h12345678);
    issue(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 32'h12345678);

    // Both requesting from reset: strict alternation 0,1,0,1
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
    @(posedge clk); #1;
    reset = 1'b0;
    c = cyc;
    push(1'b0, 1'b0, 1'b0, 32'hA0A0A0A0, c + 2);
    push(1'b1, 1'b0, 1'b0, 32'hB1B1B1B1, c + 5);
    push(1'b0, 1'b0, 1'b0, 32'hA0A0A0A0, c + 8);
    push(1'b1, 1'b0, 1'b0, 32'hB1B1B1B1, c + 11);
    repeat (11) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("rr_drained", sbq.size(), 32'd0);

    // Out-of-range write and read
    w0 = we_cycles;
    issue(1'b0, 1'b1, 32'h0001_0000, 32'h0BAD0BAD, 1'b1, 32'd0);
    chk("oor_write_no_we", we_cycles - w0, 32'd0);
    issue(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hCAFE0000);
    issue(1'b0, 1'b0, 32'h0001_0000, 32'd0, 1'b1, 32'd0);

    // Reset during a port 1 write ACCESS cycle
    w0 = we_cycles;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd20; wdata1 = 32'h55555555;
    @(posedge clk); #1;
    chk("mid_access_we", {31'b0, mem_we}, 32'd1);
    chk("mid_access_addr", {16'b0, mem_addr}, 32'd20);
    reset = 1'b1;
    #1;
    chk("async_rst_we", {31'b0, mem_we}, 32'd0);
    chk("async_rst_addr", {16'b0, mem_addr}, 32'd0);
    chk("async_rst_wdata", mem_wdata, 32'd0);
    req1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_no_ack1", {31'b0, ack1}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
    reset = 1'b0;
    c = cyc;
    push(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, c + 2);
    push(1'b1, 1'b0, 1'b0, 32'h11111111, c + 5);
    repeat (5) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_write", we_cycles - w0, 32'd0);

`ifdef DMEM_ARB_STATS_EN
    pulse_reset();
    chk("stat_rst", {16'b0, stat_cnt0 | stat_cnt1 | stat_conflict}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
    c = cyc;
    push(1'b0, 1'b0, 1'b0, 32'hA0A0A0A0, c + 2);
    push(1'b1, 1'b0, 1'b0, 32'hB1B1B1B1, c + 5);
    push(1'b0, 1'b0, 1'b0, 32'hA0A0A0A0, c + 8);
    repeat (8) @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    chk("stat_conflict", {16'b0, stat_conflict}, 32'd3);
    chk("stat_cnt0", {16'b0, stat_cnt0}, 32'd4);
    chk("stat_cnt1", {16'b0, stat_cnt1}, 32'd1);
    dut.stat_cnt0 = 16'hFFFE;
    issue(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF);
    chk("stat_cnt0_sat", {16'b0, stat_cnt0}, 32'h0000FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (word-addressed, 32-bit, combinational read, synchronous write).
- Port 0 is the CPU load/store path; port 1 is the debug/DMA loader.
- Grants the memory round-robin, drives the memory's address, write-enable and write-data inputs, registers read data, and returns a one-cycle ack per transaction.

Parameters:
- ADDR_W, 16, memory word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  transaction request, port 0 / port 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  out-of-range flag, valid with ack.
- rdata0 / rdata1  out  DATA_W  read data, valid with ack, held until the port's next ack.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory combinational read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Transitions: IDLE→ACCESS when req0|req1; ACCESS→RESP always; RESP→IDLE always. Arbitration happens only in IDLE.
- Grant and capture: the IDLE cycle with a request registers gnt_q (granted port) plus that port's we, addr and wdata into addr_q, we_q and wdata_q.
- Round-robin: last_q holds the last granted port, reset value 1.
  - Single requester: it wins.
  - Both requesting: port != last_q wins; last_q updates on every grant.
  - Two continuously requesting ports therefore alternate strictly.
- Range check: oor_q = (addr_q[31:ADDR_W] != 0), registered at grant.
- ACCESS cycle:
  - mem_addr = addr_q[ADDR_W-1:0]; mem_wdata = wdata_q; mem_we = we_q & ~oor_q.
  - The write commits at the posedge ending ACCESS.
  - On a read, mem_rd is captured into the granted port's rdata register at that same posedge; an out-of-range read captures 0.
  - A write leaves rdata unchanged.
- RESP cycle: ack for the granted port = 1, err = oor_q; the other port's ack/err = 0.
- Outside ACCESS: mem_we = 0 and mem_addr/mem_wdata hold their last values. mem_we is high for exactly one cycle per in-range write and never otherwise.
- Latency: request seen in IDLE at cycle N → ack at cycle N+2; next grant no earlier than N+3; peak throughput one transaction per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Changes to a non-granted port's inputs are ignored.
  - Dropping req before grant withdraws the request.
  - req still high in the IDLE cycle after ack is a new transaction.
- Read-after-write: a read following a write to the same address returns the new data.
- Reset values (any time, including mid-ACCESS): state = IDLE, ack0/ack1/err0/err1 = 0, rdata0/rdata1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, last_q = 1, gnt_q = 0. An ACCESS interrupted by reset commits no write. The arbiter does not clear memory contents.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0, stat_cnt1 and stat_conflict, each 16 bits.
  - stat_cnt0 / stat_cnt1 increment on each ack of their port.
  - stat_conflict increments on each IDLE grant where req0 & req1.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Port 0 read: addr0 = 5, memory[5] = 32'hDEADBEEF, req0 high in IDLE at cycle N → ack0 at N+2, rdata0 = 32'hDEADBEEF, err0 = 0, mem_we never high.
- Port 1 write then read: write addr1 = 7, wdata1 = 32'h12345678 → mem_we high exactly one cycle with mem_addr = 7; following read of addr 7 → rdata1 = 32'h12345678.
- Both req held high from reset for 4 transactions → grant order 0, 1, 0, 1; acks at 3-cycle spacing; the idle port's rdata holds its value.
- Out-of-range: addr0 = 32'h0001_0000 write → ack0 = 1, err0 = 1, mem_we stays 0, memory unchanged; the same address as a read → rdata0 = 0.
- Reset asserted during a port 1 write's ACCESS cycle → mem_we drops immediately, no write committed, no ack; after release a simultaneous request grants port 0 first.
- With DMEM_ARB_STATS_EN defined: 3 conflicting grants plus 2 solo port 0 reads → stat_conflict = 3, stat_cnt0 = 2 + (conflict grants won by port 0); saturation checked by forcing the counter to 16'hFFFE and running two transactions → 16'hFFFF.
